// File: rtl/raw_demosaic_pkg.sv
// Shared video definitions for the RAW demosaic path.
// Holds the Bayer CFA phase encodings, the fixed pipeline latency, the
// RAW/RGB sample widths and a helper that returns the colour of a sample
// from its row/column parity and the CFA phase.
package raw_demosaic_pkg;

  typedef enum logic [1:0] {
    BAYER_RGGB = 2'd0,
    BAYER_GRBG = 2'd1,
    BAYER_GBRG = 2'd2,
    BAYER_BGGR = 2'd3
  } bayer_e;

  typedef enum logic [1:0] {
    CLR_R = 2'd0,
    CLR_G = 2'd1,
    CLR_B = 2'd2
  } colour_e;

  localparam int LATENCY = 3;
  localparam int RAW_W   = 10;
  localparam int RGB_W   = 12;
  localparam int G_SUM_W = RAW_W + 1;

  // Every phase is RGGB shifted by one column (bit 0) and/or one row (bit 1),
  // so flipping the parities maps any phase back onto RGGB.
  function automatic colour_e cfa_colour(input logic [1:0] phase,
                                         input logic       row_odd,
                                         input logic       col_odd);
    logic r_sh;
    logic c_sh;
    r_sh = row_odd ^ phase[1];
    c_sh = col_odd ^ phase[0];
    if (!r_sh && !c_sh) return CLR_R;
    else if (r_sh && c_sh) return CLR_B;
    else return CLR_G;
  endfunction

endpackage

// File: rtl/line_buffer_dp.sv
// Single-port-addressed line buffer with synchronous read-before-write.
// When en is high, rdata returns the old contents of addr on the next clock
// and wdata replaces them. No reset on the array so it maps onto block RAM.
// Ports: clk, en, addr, wdata (write sample), rdata (previous contents).
module line_buffer_dp
  import raw_demosaic_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int WIDTH = RAW_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/raw_demosaic.sv
// 2x2 bilinear-style Bayer demosaic for RAW10 video.
// Each pixel's RGB comes from the 2x2 window of rows {row-1,row} and
// cols {col-1,col}; R and B are scaled to 12 bits, G is the 11-bit sum of
// the two greens scaled to 12 bits. Fixed 3-cycle latency; syncs and de are
// delayed to match. First row, first column and columns beyond MAX_H are
// output as black.
// Ports: clk, rstn (async active-low), raw_in/hsync_in/vsync_in/de_in,
//        R_out/G_out/B_out, hsync_out/vsync_out/de_out.
module raw_demosaic
  import raw_demosaic_pkg::*;
#(
  parameter int MAX_H = 2048,
  parameter int BAYER = int'(BAYER_RGGB)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [RAW_W-1:0] raw_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             de_in,
  output logic [RGB_W-1:0] R_out,
  output logic [RGB_W-1:0] G_out,
  output logic [RGB_W-1:0] B_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             de_out
);

  localparam int            AW      = $clog2(MAX_H);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] COL_MAX = CW'(MAX_H);
  localparam logic [1:0]    PHASE   = 2'(BAYER);

  logic [CW-1:0]        col;
  logic [11:0]          row;
  logic                 de_d;
  logic                 vs_d;
  logic                 armed;
  logic                 clear_pending;
  logic                 de_fall;
  logic                 vs_rise;
  logic                 lb_en;
  logic [RAW_W-1:0]     lb_rdata;
  logic [RAW_W-1:0]     rd_q;
  logic [RAW_W-1:0]     s1_cur;
  logic [RAW_W-1:0]     s1_prev;
  logic                 s1_row_odd;
  logic                 s1_col_odd;
  logic                 s1_blank;
  logic [RAW_W-1:0]     win [4];
  logic [RAW_W-1:0]     win_r;
  logic [RAW_W-1:0]     win_b;
  logic [G_SUM_W-1:0]   win_g;
  logic [RAW_W-1:0]     s2_r;
  logic [RAW_W-1:0]     s2_b;
  logic [G_SUM_W-1:0]   s2_g;
  logic                 s2_blank;
  logic [LATENCY-1:0]   de_sr;
  logic [LATENCY-1:0]   hs_sr;
  logic [LATENCY-1:0]   vs_sr;

  // A line cut short by reset is not counted: 'armed' only rises once de_in
  // has been seen low, so the first complete line after reset is row 0.
  assign de_fall = de_d & ~de_in & armed;
  assign vs_rise = vsync_in & ~vs_d;
  assign lb_en   = de_in & (col < COL_MAX);

  // Column/row position tracking. A vsync rise during an active line is held
  // in clear_pending so the current line keeps its row number.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      col           <= '0;
      row           <= '0;
      de_d          <= 1'b0;
      vs_d          <= 1'b0;
      armed         <= 1'b0;
      clear_pending <= 1'b0;
    end else begin
      de_d  <= de_in;
      vs_d  <= vsync_in;
      armed <= armed | ~de_in;
      if (!de_in)              col <= '0;
      else if (col != COL_MAX) col <= col + CW'(1);
      if (vs_rise && !de_in) begin
        row           <= '0;
        clear_pending <= 1'b0;
      end else begin
        if (vs_rise) clear_pending <= 1'b1;
        if (de_fall) begin
          row           <= clear_pending ? 12'd0 : row + 12'd1;
          clear_pending <= 1'b0;
        end
      end
    end
  end

  line_buffer_dp #(
    .DEPTH (MAX_H),
    .WIDTH (RAW_W)
  ) u_line_buf (
    .clk   (clk),
    .en    (lb_en),
    .addr  (col[AW-1:0]),
    .wdata (raw_in),
    .rdata (lb_rdata)
  );

  // Stage 1: capture current/previous samples and the previous-row sample
  // of the prior column; lb_rdata itself is the previous row at this column.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_q       <= '0;
      s1_cur     <= '0;
      s1_prev    <= '0;
      s1_row_odd <= 1'b0;
      s1_col_odd <= 1'b0;
      s1_blank   <= 1'b1;
    end else begin
      rd_q       <= lb_rdata;
      s1_cur     <= raw_in;
      s1_prev    <= s1_cur;
      s1_row_odd <= row[0];
      s1_col_odd <= col[0];
      s1_blank   <= ~de_in | (row == 12'd0) | (col == '0) | (col >= COL_MAX);
    end
  end

  // Window order: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
  assign win[0] = rd_q;
  assign win[1] = lb_rdata;
  assign win[2] = s1_prev;
  assign win[3] = s1_cur;

  always_comb begin
    win_r = '0;
    win_g = '0;
    win_b = '0;
    for (int i = 0; i < 4; i++) begin
      case (cfa_colour(PHASE,
                       (i >= 2) ? s1_row_odd : ~s1_row_odd,
                       ((i % 2) == 1) ? s1_col_odd : ~s1_col_odd))
        CLR_R:   win_r = win[i];
        CLR_B:   win_b = win[i];
        default: win_g = win_g + G_SUM_W'(win[i]);
      endcase
    end
  end

  // Stage 2: register the colour-sorted window.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
      s2_blank <= 1'b1;
    end else begin
      s2_r     <= win_r;
      s2_g     <= win_g;
      s2_b     <= win_b;
      s2_blank <= s1_blank;
    end
  end

  // Stage 3: scale to 12 bits and black out edge/inactive pixels.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      R_out <= '0;
      G_out <= '0;
      B_out <= '0;
    end else begin
      R_out <= s2_blank ? '0 : {s2_r, 2'b00};
      G_out <= s2_blank ? '0 : {s2_g, 1'b0};
      B_out <= s2_blank ? '0 : {s2_b, 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      de_sr <= '0;
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      de_sr <= {de_sr[LATENCY-2:0], de_in};
      hs_sr <= {hs_sr[LATENCY-2:0], hsync_in};
      vs_sr <= {vs_sr[LATENCY-2:0], vsync_in};
    end
  end

  assign de_out    = de_sr[LATENCY-1];
  assign hsync_out = hs_sr[LATENCY-1];
  assign vsync_out = vs_sr[LATENCY-1];

endmodule

// File: tb/tb_raw_demosaic.sv
// Testbench for raw_demosaic: four instances (one per Bayer phase) share the
// sync/de stream, each with its own RAW image. Expected outputs come from a
// frame-level reference model and are queued per input cycle; a monitor pops
// and compares when the matching output cycle arrives.
module tb_raw_demosaic;

  localparam int MAX_H = 16;
  localparam int NB    = 4;
  localparam int ROWS  = 8;
  localparam int COLS  = MAX_H + 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [9:0]  raw_in [NB];
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        de_in = 1'b0;
  logic [11:0] r_out [NB];
  logic [11:0] g_out [NB];
  logic [11:0] b_out [NB];
  logic        hs_out [NB];
  logic        vs_out [NB];
  logic        de_out [NB];

  genvar gb;
  generate
    for (gb = 0; gb < NB; gb++) begin : g_dut
      raw_demosaic #(.MAX_H(MAX_H), .BAYER(gb)) u_dut (
        .clk       (clk),
        .rstn      (rstn),
        .raw_in    (raw_in[gb]),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .de_in     (de_in),
        .R_out     (r_out[gb]),
        .G_out     (g_out[gb]),
        .B_out     (b_out[gb]),
        .hsync_out (hs_out[gb]),
        .vsync_out (vs_out[gb]),
        .de_out    (de_out[gb])
      );
    end
  endgenerate

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [31:0]           samp;
    logic                  de;
    logic                  hs;
    logic                  vs;
    logic [NB-1:0][11:0]   r;
    logic [NB-1:0][11:0]   g;
    logic [NB-1:0][11:0]   b;
  } exp_t;

  exp_t sb[$];

  logic [9:0] img [NB][ROWS][COLS];

  // CFA layout per phase, indexed [phase][2*row_parity + col_parity]:
  // 0=R, 1=G, 2=B. RGGB, GRBG, GBRG, BGGR.
  int cfa_tab [NB][4] = '{'{0, 1, 1, 2}, '{1, 0, 2, 1}, '{1, 2, 0, 1}, '{2, 1, 1, 0}};

  function automatic logic [35:0] model_px(input int b, input int r, input int c);
    int rs, gs, bs, rr, cc, v;
    if (r == 0 || c == 0 || c >= MAX_H) return 36'd0;
    rs = 0; gs = 0; bs = 0;
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        rr = r - 1 + dr;
        cc = c - 1 + dc;
        v  = int'(img[b][rr][cc]);
        case (cfa_tab[b][2 * (rr % 2) + (cc % 2)])
          0:       rs += v;
          1:       gs += v;
          default: bs += v;
        endcase
      end
    end
    return {12'(rs * 4), 12'(gs * 2), 12'(bs * 4)};
  endfunction

  task automatic applyStimulus(input logic de, input logic hs, input logic vs,
                               input int r, input int c);
    exp_t e;
    logic [35:0] px;
    @(negedge clk);
    de_in    = de;
    hsync_in = hs;
    vsync_in = vs;
    e      = '0;
    e.samp = 32'(cyc + 1);
    e.de   = de;
    e.hs   = hs;
    e.vs   = vs;
    for (int b = 0; b < NB; b++) begin
      if (de) begin
        raw_in[b] = img[b][r][c];
        px        = model_px(b, r, c);
        e.r[b]    = px[35:24];
        e.g[b]    = px[23:12];
        e.b[b]    = px[11:0];
      end else begin
        raw_in[b] = 10'($urandom);
      end
    end
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if ({de_out[b], hs_out[b], vs_out[b], r_out[b], g_out[b], b_out[b]} !==
          {e.de, e.hs, e.vs, e.r[b], e.g[b], e.b[b]}) begin
        $display("[TB] FAIL pixel bayer=%0d samp=%0d got de/hs/vs=%b%b%b RGB=%h,%h,%h required de/hs/vs=%b%b%b RGB=%h,%h,%h",
                 b, e.samp, de_out[b], hs_out[b], vs_out[b], r_out[b], g_out[b], b_out[b],
                 e.de, e.hs, e.vs, e.r[b], e.g[b], e.b[b]);
      end else begin
        n_pass++;
      end
    end
  endtask

  task automatic checkZero(input string tag);
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if ({de_out[b], hs_out[b], vs_out[b], r_out[b], g_out[b], b_out[b]} !== 39'd0) begin
        $display("[TB] FAIL %s bayer=%0d got de/hs/vs=%b%b%b RGB=%h,%h,%h required all zero",
                 tag, b, de_out[b], hs_out[b], vs_out[b], r_out[b], g_out[b], b_out[b]);
      end else begin
        n_pass++;
      end
    end
  endtask

  // Monitor: one output cycle per input cycle, exactly 3 clocks later.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rstn) begin
        if (sb.size() > 0 && int'(sb[0].samp) == cyc - 2) begin
          checkOutput(sb.pop_front());
        end else if (de_out[0]) begin
          n_checks++;
          $display("[TB] FAIL unexpected_de cyc=%0d got de_out=1 required 0", cyc);
        end
      end
    end
  end

  task automatic fillRandom();
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          img[b][r][c] = 10'($urandom);
  endtask

  task automatic fillConst(input logic [9:0] v);
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          img[b][r][c] = v;
  endtask

  // target colour (0=R,1=G) set to full scale; other samples zero or random
  task automatic fillColour(input int colour, input bit rand_other);
    for (int b = 0; b < NB; b++)
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (cfa_tab[b][2 * (r % 2) + (c % 2)] == colour) img[b][r][c] = 10'h3FF;
          else img[b][r][c] = rand_other ? 10'($urandom) : 10'h000;
  endtask

  task automatic sendFrame(input int h, input int w, input int long_row,
                           input bit do_vsync, input bit vs_mid, input int blank);
    int wr;
    if (do_vsync) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 0, 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    end
    for (int r = 0; r < h; r++) begin
      wr = (r == long_row) ? MAX_H + 4 : w;
      for (int c = 0; c < wr; c++)
        applyStimulus(1'b1, 1'b0, vs_mid && (r == h - 1) && (c >= wr / 2), r, c);
      for (int k = 0; k < blank; k++)
        applyStimulus(1'b0, k == 0, vs_mid && (r == h - 1), 0, 0);
    end
  endtask

  task automatic resetMidLine();
    @(negedge clk);
    #2;
    rstn  = 1'b0;
    de_in = 1'b0;
    sb.delete();
    #1;
    checkZero("reset_immediate");
    repeat (3) @(negedge clk);
    checkZero("reset_held");
    rstn = 1'b1;
  endtask

  initial begin
    for (int b = 0; b < NB; b++) raw_in[b] = '0;
    repeat (2) @(negedge clk);
    checkZero("reset_state");
    rstn = 1'b1;

    fillConst(10'h200);
    sendFrame(8, 8, -1, 1'b1, 1'b0, 2);

    fillColour(0, 1'b0);
    sendFrame(8, 8, -1, 1'b1, 1'b0, 2);

    fillColour(1, 1'b1);
    sendFrame(6, 16, -1, 1'b1, 1'b0, 1);

    fillRandom();
    sendFrame(8, 16, -1, 1'b1, 1'b1, 1);
    fillRandom();
    sendFrame(5, 12, -1, 1'b0, 1'b0, 1);

    fillRandom();
    sendFrame(6, 16, 2, 1'b1, 1'b0, 3);

    fillRandom();
    sendFrame(3, 8, -1, 1'b1, 1'b0, 2);
    for (int c = 0; c < 4; c++) applyStimulus(1'b1, 1'b0, 1'b0, 3, c);
    resetMidLine();
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
    fillRandom();
    sendFrame(3, 8, -1, 1'b0, 1'b0, 2);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      n_checks++;
      $display("[TB] FAIL drain got %0d pending outputs required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
